alu_cmd_driver: RTL and testbench

- Initiator-side front end for the 16-bit registered ALU.
- Accepts operation commands over a valid/ready handshake and drives A, B and ALU_FUN into the ALU.
- Waits out the ALU's registered latency, then captures ALU_OUT and the five flags into a held result with its own valid/ready handshake.
- Checks the returned class flag against the issued opcode and rejects the unused opcode 4'b1111 without issuing it.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_cmd_driver_flag_checker.sv | 16 +
 rtl/alu_cmd_driver.sv | 191 +++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit registered ALU and its command driver:
// opcodes, flag bit positions, driver FSM encoding and the opcode-to-class map.
package alu_pkg;

  localparam logic [3:0] ADD     = 4'd0;
  localparam logic [3:0] SUB     = 4'd1;
  localparam logic [3:0] MUL     = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] AND     = 4'd4;
  localparam logic [3:0] OR      = 4'd5;
  localparam logic [3:0] NAND    = 4'd6;
  localparam logic [3:0] NOR     = 4'd7;
  localparam logic [3:0] XOR     = 4'd8;
  localparam logic [3:0] XNOR    = 4'd9;
  localparam logic [3:0] CMPEQ   = 4'd10;
  localparam logic [3:0] CMPG    = 4'd11;
  localparam logic [3:0] CMPL    = 4'd12;
  localparam logic [3:0] SHR     = 4'd13;
  localparam logic [3:0] SHL     = 4'd14;
  localparam logic [3:0] ILLEGAL = 4'd15;

  // Bit positions inside the 5-bit flag vector {Carry, Arith, Logic, CMP, Shift}
  localparam int CARRY = 4;
  localparam int ARITH = 3;
  localparam int LOGIC = 2;
  localparam int CMP   = 1;
  localparam int SHIFT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // One-hot class the ALU must raise on flags[3:0] for a given opcode.
  function automatic logic [3:0] expected_class(input logic [3:0] fun);
    logic [3:0] cls;
    cls = 4'b0000;
    if (fun <= DIV) begin
      cls = 4'b1000;
    end else if (fun <= XNOR) begin
      cls = 4'b0100;
    end else if (fun <= CMPL) begin
      cls = 4'b0010;
    end else if (fun <= SHL) begin
      cls = 4'b0001;
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_flag_checker.sv
// Combinational check that the class flags returned by the ALU match the
// one-hot class implied by the opcode that was issued.
module alu_flag_checker
  import alu_pkg::*;
(
  input  logic [3:0] i_fun,
  input  logic [3:0] i_class_flags,
  output logic       o_mismatch
);

  logic [3:0] w_expected;

  assign w_expected = expected_class(i_fun);
  assign o_mismatch = (i_class_flags != w_expected);

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator front end for the registered ALU: accepts a command, drives the
// ALU, waits out its latency and holds the captured result for a consumer.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [DATA_W-1:0] CMD_A,
  input  logic [DATA_W-1:0] CMD_B,
  input  logic [FUN_W-1:0]  CMD_FUN,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [4:0]        ALU_FLAGS,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [DATA_W-1:0] RES_DATA,
  output logic [4:0]        RES_FLAGS,
  output logic              RES_ERR,
  output logic [CNT_W-1:0]  OP_COUNT
);

  localparam int WAIT_W = 3;
  localparam logic [FUN_W-1:0]  FUN_ILLEGAL = FUN_W'(ILLEGAL);
  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(ALU_LAT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  logic                r_cmd_ready;
  logic                w_cmd_ready_next;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   w_alu_a_next;
  logic [DATA_W-1:0]   r_alu_b;
  logic [DATA_W-1:0]   w_alu_b_next;
  logic [FUN_W-1:0]    r_alu_fun;
  logic [FUN_W-1:0]    w_alu_fun_next;
  logic                r_res_valid;
  logic                w_res_valid_next;
  logic [DATA_W-1:0]   r_res_data;
  logic [DATA_W-1:0]   w_res_data_next;
  logic [4:0]          r_res_flags;
  logic [4:0]          w_res_flags_next;
  logic                r_res_err;
  logic                w_res_err_next;
  logic [CNT_W-1:0]    r_op_count;
  logic [CNT_W-1:0]    w_op_count_next;

  logic                w_cmd_fire;
  logic                w_cmd_illegal;
  logic                w_res_fire;
  logic                w_class_mismatch;

  assign w_cmd_fire    = CMD_VALID & r_cmd_ready;
  assign w_cmd_illegal = (CMD_FUN == FUN_ILLEGAL);
  assign w_res_fire    = r_res_valid & RES_READY;

  // r_alu_fun still holds the issued opcode during CAPT, so it is checked here.
  alu_flag_checker u_flag_checker (
    .i_fun         (r_alu_fun[3:0]),
    .i_class_flags (ALU_FLAGS[3:0]),
    .o_mismatch    (w_class_mismatch)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_cmd_ready <= 1'b1;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= FUN_ILLEGAL;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_res_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wait      <= w_wait_next;
      r_cmd_ready <= w_cmd_ready_next;
      r_alu_a     <= w_alu_a_next;
      r_alu_b     <= w_alu_b_next;
      r_alu_fun   <= w_alu_fun_next;
      r_res_valid <= w_res_valid_next;
      r_res_data  <= w_res_data_next;
      r_res_flags <= w_res_flags_next;
      r_res_err   <= w_res_err_next;
      r_op_count  <= w_op_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_state_next = w_cmd_illegal ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_wait == '0) begin
          w_state_next = ST_CAPT;
        end
      end
      ST_CAPT: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (w_res_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_wait_next      = r_wait;
    w_alu_a_next     = r_alu_a;
    w_alu_b_next     = r_alu_b;
    w_alu_fun_next   = r_alu_fun;
    w_res_valid_next = r_res_valid;
    w_res_data_next  = r_res_data;
    w_res_flags_next = r_res_flags;
    w_res_err_next   = r_res_err;
    w_op_count_next  = r_op_count;
    w_cmd_ready_next = (w_state_next == ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          if (w_cmd_illegal) begin
            // Rejected locally; the ALU never sees this command.
            w_res_data_next  = '0;
            w_res_flags_next = '0;
            w_res_err_next   = 1'b1;
            w_res_valid_next = 1'b1;
          end else begin
            w_alu_a_next   = CMD_A;
            w_alu_b_next   = CMD_B;
            w_alu_fun_next = CMD_FUN;
            w_wait_next    = WAIT_LOAD;
          end
        end
      end
      ST_EXEC: begin
        if (r_wait != '0) begin
          w_wait_next = r_wait - WAIT_W'(1);
        end
      end
      ST_CAPT: begin
        w_res_data_next  = ALU_OUT;
        w_res_flags_next = ALU_FLAGS;
        w_res_err_next   = w_class_mismatch;
        w_res_valid_next = 1'b1;
        w_alu_fun_next   = FUN_ILLEGAL;
      end
      ST_RESP: begin
        if (w_res_fire) begin
          w_res_valid_next = 1'b0;
          w_op_count_next  = r_op_count + CNT_W'(1);
        end
      end
      default: begin
        w_res_valid_next = 1'b0;
      end
    endcase
  end

  assign CMD_READY = r_cmd_ready;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign RES_VALID = r_res_valid;
  assign RES_DATA  = r_res_data;
  assign RES_FLAGS = r_res_flags;
  assign RES_ERR   = r_res_err;
  assign OP_COUNT  = r_op_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a registered ALU model and a result
// scoreboard; one line is printed per completed transaction.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out = '0;
  logic [4:0]  alu_flags = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [4:0]  res_flags;
  logic        res_err;
  logic [15:0] op_count;
  logic        inj_bad = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  flags;
    logic        err;
  } exp_t;
  exp_t sb[$];

  alu_cmd_driver #(.DATA_W(16), .FUN_W(4), .ALU_LAT(1), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_FUN(cmd_fun),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
    .ALU_OUT(alu_out), .ALU_FLAGS(alu_flags),
    .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_DATA(res_data), .RES_FLAGS(res_flags), .RES_ERR(res_err),
    .OP_COUNT(op_count)
  );

  always #5 clk = ~clk;

  // Registered ALU behaviour (one edge of latency); inj_bad corrupts ADD's class.
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f, input logic bad);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  fl;
    r = '0; fl = '0; s = '0;
    case (f)
      ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[15:0];
                   fl = bad ? {s[16], 4'b0100} : {s[16], 4'b1000}; end
      SUB:   begin r = a - b; fl = {(a < b), 4'b1000}; end
      MUL:   begin r = a * b; fl = 5'b01000; end
      DIV:   begin r = (b == 0) ? 16'h0 : a / b; fl = 5'b01000; end
      AND:   begin r = a & b; fl = 5'b00100; end
      OR:    begin r = a | b; fl = 5'b00100; end
      NAND:  begin r = ~(a & b); fl = 5'b00100; end
      NOR:   begin r = ~(a | b); fl = 5'b00100; end
      XOR:   begin r = a ^ b; fl = 5'b00100; end
      XNOR:  begin r = ~(a ^ b); fl = 5'b00100; end
      CMPEQ: begin r = (a == b) ? 16'd1 : 16'd0; fl = 5'b00010; end
      CMPG:  begin r = (a > b) ? 16'd2 : 16'd0; fl = 5'b00010; end
      CMPL:  begin r = (a < b) ? 16'd3 : 16'd0; fl = 5'b00010; end
      SHR:   begin r = a >> 1; fl = 5'b00001; end
      SHL:   begin r = a << 1; fl = 5'b00001; end
      default: begin r = '0; fl = '0; end
    endcase
    return {r, fl};
  endfunction

  always @(posedge clk) begin
    {alu_out, alu_flags} <= alu_model(alu_a, alu_b, alu_fun, inj_bad);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd_ready();
    int cyc;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                        input int hold, input logic ready_early,
                        input logic [15:0] e_data, input logic [4:0] e_flags,
                        input logic e_err, input int e_lat);
    int          cyc;
    logic [15:0] cnt0, prev_a, prev_b;
    exp_t        ex;
    wait_cmd_ready();
    cnt0   = op_count;
    prev_a = alu_a;
    prev_b = alu_b;
    cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_valid = 1'b1;
    res_ready = ready_early;
    sb.push_back('{e_data, e_flags, e_err});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_fun = 4'($urandom);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin
      check("busy_cmd_ready", cmd_ready, 0);
      if (fun != ILLEGAL) begin
        check("alu_a_stable", alu_a, a);
        check("alu_fun_stable", alu_fun, fun);
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, e_lat);
    check("resp_alu_fun", alu_fun, ILLEGAL);
    check("resp_cmd_ready", cmd_ready, 0);
    if (fun == ILLEGAL) begin
      check("illegal_alu_a", alu_a, prev_a);
      check("illegal_alu_b", alu_b, prev_b);
    end
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      check("res_data", res_data, ex.data);
      check("res_flags", res_flags, ex.flags);
      check("res_err", res_err, ex.err);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, ex.data);
        check("hold_flags", res_flags, ex.flags);
        check("hold_count", op_count, cnt0);
        check("hold_cmd_ready", cmd_ready, 0);
      end
    end else begin
      check("scoreboard_nonempty", 0, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_count", op_count, 16'(cnt0 + 16'd1));
    check("post_cmd_ready", cmd_ready, 1);
    $display("op fun=%0d a=%h b=%h -> data=%h flags=%b err=%b count=%0d",
             fun, a, b, e_data, e_flags, e_err, op_count);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_alu_fun"}, alu_fun, ILLEGAL);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_res_err"}, res_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check("reset_res_data", res_data, 0);
    check("reset_res_flags", res_flags, 0);
    check("reset_alu_b", alu_b, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'hFFFF, 16'h0001, ADD,     0, 1'b0, 16'h0000, 5'b11000, 1'b0, 2);
    run_op(16'h0000, 16'h0001, SUB,     0, 1'b0, 16'hFFFF, 5'b11000, 1'b0, 2);
    run_op(16'h0005, 16'h0003, CMPG,    0, 1'b0, 16'h0002, 5'b00010, 1'b0, 2);
    run_op(16'h1234, 16'h5678, ILLEGAL, 0, 1'b0, 16'h0000, 5'b00000, 1'b1, 0);
    run_op(16'h8001, 16'h0000, SHL,     5, 1'b0, 16'h0002, 5'b00001, 1'b0, 2);
    run_op(16'hF0F0, 16'h3C3C, AND,     0, 1'b1, 16'h3030, 5'b00100, 1'b0, 2);
    inj_bad = 1'b1;
    run_op(16'h0001, 16'h0002, ADD,     0, 1'b0, 16'h0003, 5'b00100, 1'b1, 2);
    inj_bad = 1'b0;
    run_op(16'h00FF, 16'h0F0F, XOR,     0, 1'b0, 16'h0FF0, 5'b00100, 1'b0, 2);
    run_op(16'h8001, 16'h0000, SHR,     0, 1'b0, 16'h4000, 5'b00001, 1'b0, 2);
    run_op(16'h0007, 16'h0007, CMPEQ,   0, 1'b0, 16'h0001, 5'b00010, 1'b0, 2);
    run_op(16'h0003, 16'h0004, MUL,     0, 1'b1, 16'h000C, 5'b01000, 1'b0, 2);
    check("count_before_reset", op_count, 11);

    // Reset while the ALU is executing.
    wait_cmd_ready();
    cmd_a = 16'h0011; cmd_b = 16'h0022; cmd_fun = ADD; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_exec");
    run_op(16'h0002, 16'h0003, ADD, 0, 1'b0, 16'h0005, 5'b01000, 1'b0, 2);

    // Reset while a result is being held.
    wait_cmd_ready();
    cmd_a = 16'h0009; cmd_b = 16'h0001; cmd_fun = SUB; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_resp_valid", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_resp");
    check("rst_resp_res_data", res_data, 0);
    run_op(16'h0005, 16'h0003, SUB, 0, 1'b0, 16'h0002, 5'b01000, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
